// File: rtl/cpu_csr_pkg.sv
// Shared definitions for the machine-mode CSR file and local interrupt controller:
// CSR addresses, trap cause codes, the interrupt flag and the trap state enum.
package cpu_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MTIMECMP  = 12'h7C0;
  localparam logic [11:0] CSR_MTIMECMPH = 12'h7C1;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_TIME      = 12'hC01;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_TIMEH     = 12'hC81;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [4:0] CODE_MSI        = 5'd3;
  localparam logic [4:0] CODE_MTI        = 5'd7;
  localparam logic [4:0] CODE_MEI        = 5'd11;
  localparam logic [4:0] CODE_LOCAL_BASE = 5'd16;

  localparam logic [3:0] EXC_ILLEGAL    = 4'd2;
  localparam logic [3:0] EXC_BREAKPOINT = 4'd3;
  localparam logic [3:0] EXC_ECALL_M    = 4'd11;

  localparam logic [31:0] INTERRUPT_BIT = 32'h8000_0000;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } state_t;

endpackage

// File: rtl/cpu_csr_timer.sv
// Free-running cycle counter, 1 kHz mtime with prescaler, 64-bit mtimecmp and
// the machine timer interrupt compare.
module cpu_csr_timer #(
  parameter int unsigned FREQUENCY = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmp_lo_wr,
  input  logic        cmp_hi_wr,
  input  logic [31:0] wdata,
  output logic [63:0] cycle,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        mtip
);

  // A clock slower than 1 kHz (or the default 0) degenerates to one tick per cycle.
  localparam int unsigned PRESCALE = (FREQUENCY / 1000 > 1) ? FREQUENCY / 1000 : 1;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] prescale;
  logic          tick;

  assign tick = (prescale == PRESCALE_LAST);

  // NOTE: registers are assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescale <= '0;
      cycle    <= '0;
      mtime    <= '0;
      mtimecmp <= '1;
    end else begin
      cycle <= cycle + 64'd1;
      if (tick) begin
        prescale <= '0;
        mtime    <= mtime + 64'd1;
      end else begin
        prescale <= prescale + 1'b1;
      end
      if (cmp_lo_wr) mtimecmp[31:0]  <= wdata;
      if (cmp_hi_wr) mtimecmp[63:32] <= wdata;
    end
  end

  assign mtip = (mtime >= mtimecmp);

endmodule

// File: rtl/cpu_csr_clint.sv
// Machine-mode CSR file and local interrupt controller. Vectored trap dispatch
// (mtvec mode 01) is built only when CPU_CSR_VECTORED_EN is defined.
module cpu_csr_clint
  import cpu_csr_pkg::*;
#(
  parameter int unsigned FREQUENCY = 0,
  parameter logic [31:0] VENDORID  = '0,
  parameter logic [31:0] ARCHID    = '0,
  parameter logic [31:0] IMPID     = '0,
  parameter logic [31:0] HARTID    = '0,
  parameter int          IRQ_LINES = 4
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [IRQ_LINES-1:0] i_irq_lines,
  input  logic                 i_external_interrupt,
  input  logic                 i_exception,
  input  logic [3:0]           i_exc_cause,
  input  logic [31:0]          i_exc_tval,
  input  logic                 i_mret,
  input  logic [11:0]          i_index,
  output logic [31:0]          o_rdata,
  input  logic                 i_wdata_wr,
  input  logic [31:0]          i_wdata,
  input  logic [63:0]          i_retired,
  output logic [31:0]          o_epc,
  output logic                 o_irq_pending,
  output logic [31:0]          o_irq_pc,
  input  logic                 i_irq_dispatched,
  input  logic [31:0]          i_irq_epc
);

  localparam logic [31:0] LOCAL_MASK = 32'(((64'd1 << IRQ_LINES) - 64'd1) << 16);
  localparam logic [31:0] MIE_MASK   = LOCAL_MASK | 32'h0000_0888;
  localparam logic [31:0] MIP_CLEAR  = LOCAL_MASK | 32'h0000_0800;
  localparam logic [31:0] MSIP_BIT   = 32'h0000_0008;

  logic        mstatus_mie, mstatus_mpie;
  logic [31:0] mie, mip, mtvec, mscratch, mepc, mcause, mtval;
  logic [31:0] mip_view, mip_next, pending_en;
  logic [63:0] cycle, mtime, mtimecmp;
  logic        mtip;

  state_t      state;
  logic [4:0]  taken_code;
  logic        taken_irq;

  logic        irq_valid, local_hit;
  logic [4:0]  irq_code, local_code, take_code;
  logic        take_exc, take_irq, take, dispatch;
  logic [31:0] trap_base, trap_pc;

  cpu_csr_timer #(.FREQUENCY(FREQUENCY)) u_timer (
    .clk      (i_clock),
    .reset    (i_reset),
    .cmp_lo_wr(i_wdata_wr && i_index == CSR_MTIMECMP),
    .cmp_hi_wr(i_wdata_wr && i_index == CSR_MTIMECMPH),
    .wdata    (i_wdata),
    .cycle    (cycle),
    .mtime    (mtime),
    .mtimecmp (mtimecmp),
    .mtip     (mtip)
  );

  assign mip_view   = mip | ({31'b0, mtip} << CODE_MTI);
  assign pending_en = mip_view & mie;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    irq_valid  = 1'b1;
    irq_code   = CODE_MTI;
    local_hit  = 1'b0;
    local_code = CODE_LOCAL_BASE;
    // Walk downward so the lowest active line is the one left standing.
    for (int k = IRQ_LINES - 1; k >= 0; k--) begin
      if (pending_en[16 + k]) begin
        local_hit  = 1'b1;
        local_code = CODE_LOCAL_BASE + 5'(k);
      end
    end
    if (pending_en[CODE_MEI])      irq_code = CODE_MEI;
    else if (local_hit)            irq_code = local_code;
    else if (pending_en[CODE_MSI]) irq_code = CODE_MSI;
    else if (pending_en[CODE_MTI]) irq_code = CODE_MTI;
    else                           irq_valid = 1'b0;
  end

  assign take_exc  = (state == ST_IDLE) && !i_mret && i_exception;
  assign take_irq  = (state == ST_IDLE) && !i_mret && !i_exception && mstatus_mie && irq_valid;
  assign take      = take_exc || take_irq;
  assign take_code = take_exc ? {1'b0, i_exc_cause} : irq_code;
  assign dispatch  = (state == ST_PENDING) && i_irq_dispatched;

  assign trap_base = {mtvec[31:2], 2'b00};
`ifdef CPU_CSR_VECTORED_EN
  assign trap_pc = (take_irq && mtvec[1:0] == 2'b01) ?
                   trap_base + {25'b0, take_code, 2'b00} : trap_base;
`else
  assign trap_pc = trap_base;
`endif

  // Line sets are merged last so they win over a same-cycle software or dispatch clear.
  always_comb begin
    mip_next = mip;
    if (i_wdata_wr && i_index == CSR_MIP)
      mip_next = (mip & i_wdata & MIP_CLEAR) | (i_wdata & MSIP_BIT);
    if (dispatch && taken_irq && taken_code != CODE_MTI)
      mip_next[taken_code] = 1'b0;
    mip_next = mip_next | (32'(i_irq_lines) << 16) |
               ({31'b0, i_external_interrupt} << CODE_MEI);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= ST_IDLE;
      o_irq_pending <= 1'b0;
      o_irq_pc      <= '0;
      taken_code    <= '0;
      taken_irq     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (take) begin
          state         <= ST_PENDING;
          o_irq_pending <= 1'b1;
          o_irq_pc      <= trap_pc;
          taken_code    <= take_code;
          taken_irq     <= take_irq;
        end
        ST_PENDING: if (i_irq_dispatched) begin
          state         <= ST_IDLE;
          o_irq_pending <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie          <= '0;
      mip          <= '0;
      mtvec        <= '0;
      mscratch     <= '0;
      mepc         <= '0;
      mcause       <= '0;
      mtval        <= '0;
    end else begin
      mip <= mip_next;

      if (take) begin
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (i_mret) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (i_wdata_wr && i_index == CSR_MSTATUS) begin
        mstatus_mie  <= i_wdata[MSTATUS_MIE];
        mstatus_mpie <= i_wdata[MSTATUS_MPIE];
      end

      if (i_wdata_wr && i_index == CSR_MIE) mie <= i_wdata & MIE_MASK;
`ifdef CPU_CSR_VECTORED_EN
      if (i_wdata_wr && i_index == CSR_MTVEC) mtvec <= i_wdata;
`else
      if (i_wdata_wr && i_index == CSR_MTVEC) mtvec <= {i_wdata[31:2], 2'b00};
`endif
      if (i_wdata_wr && i_index == CSR_MSCRATCH) mscratch <= i_wdata;

      if (dispatch)                               mepc <= i_irq_epc;
      else if (i_wdata_wr && i_index == CSR_MEPC) mepc <= i_wdata;

      if (take) begin
        mcause <= take_exc ? {28'b0, i_exc_cause} : (INTERRUPT_BIT | {27'b0, irq_code});
        mtval  <= take_exc ? i_exc_tval : 32'b0;
      end else begin
        if (i_wdata_wr && i_index == CSR_MCAUSE) mcause <= i_wdata;
        if (i_wdata_wr && i_index == CSR_MTVAL)  mtval  <= i_wdata;
      end
    end
  end

  always_comb begin
    o_rdata = '0;
    case (i_index)
      CSR_MSTATUS: begin
        o_rdata[MSTATUS_MIE]  = mstatus_mie;
        o_rdata[MSTATUS_MPIE] = mstatus_mpie;
      end
      CSR_MIE:       o_rdata = mie;
      CSR_MTVEC:     o_rdata = mtvec;
      CSR_MSCRATCH:  o_rdata = mscratch;
      CSR_MEPC:      o_rdata = mepc;
      CSR_MCAUSE:    o_rdata = mcause;
      CSR_MTVAL:     o_rdata = mtval;
      CSR_MIP:       o_rdata = mip_view;
      CSR_MTIMECMP:  o_rdata = mtimecmp[31:0];
      CSR_MTIMECMPH: o_rdata = mtimecmp[63:32];
      CSR_CYCLE:     o_rdata = cycle[31:0];
      CSR_CYCLEH:    o_rdata = cycle[63:32];
      CSR_TIME:      o_rdata = mtime[31:0];
      CSR_TIMEH:     o_rdata = mtime[63:32];
      CSR_INSTRET:   o_rdata = i_retired[31:0];
      CSR_INSTRETH:  o_rdata = i_retired[63:32];
      CSR_MVENDORID: o_rdata = VENDORID;
      CSR_MARCHID:   o_rdata = ARCHID;
      CSR_MIMPID:    o_rdata = IMPID;
      CSR_MHARTID:   o_rdata = HARTID;
      default:       o_rdata = '0;
    endcase
  end

  assign o_epc = mepc;

endmodule
